duty_ramp: RTL
==============

// Module: duty_ramp
// PURPOSE
//   Slew-rate limiter between the I2C register slave and the PWM generator.
//   Latches the duty target written over I2C and walks duty_out toward it by
//   STEP every RAMP_DIV clocks, so motor/servo duty never jumps. duty_out drives
//   the PWM generator duty input directly.
// PARAMETERS
//   WIDTH       8           duty/target width in bits
//   RAMP_DIV    1000        clocks per ramp step; legal range >= 1 (1 = step every clock)
//   STEP        1           duty increment per step; legal range 1 .. 2**WIDTH-1
//   WDT_CYCLES  50_000_000  watchdog timeout in clocks, used only with DUTY_WDT_EN; >= 2
// PORTS
//   clk           in   1      system clock; all state on rising edge
//   rst           in   1      asynchronous active-low reset
//   target_in     in   WIDTH  new duty target from I2C slave
//   target_valid  in   1      1-cycle strobe; target_in sampled when high
//   duty_out      out  WIDTH  current ramped duty (registered)
//   at_target     out  1      1 when duty_out == target register
//   ramping       out  1      1 when duty_out != target register (= ~at_target)
//   wdt_tripped   out  1      watchdog timeout flag (tied 0 without DUTY_WDT_EN)
// BEHAVIOUR
//   Reset (rst low, async, takes effect immediately): target=0, duty_out=0, prescaler=0,
//     wdt count=0, wdt_tripped=0 -> at_target=1, ramping=0. Mid-ramp reset aborts ramp.
//   Target latch: target_valid high at edge N -> target=target_in after edge N.
//   States (derived from registers): IDLE (duty_out==target), UP (<), DOWN (>).
//   Prescaler: held at 0 in IDLE; in UP/DOWN increments each edge; when it equals
//     RAMP_DIV-1 the edge is a tick: prescaler wraps to 0 and a step is applied.
//   First step lands RAMP_DIV edges after the latching edge (edge N+RAMP_DIV).
//   Step UP: duty_out = min(duty_out+STEP, target), computed in WIDTH+1 bits; no wrap.
//   Step DOWN: duty_out = max(duty_out-STEP, target), WIDTH+1-bit signed-safe; no underflow.
//   Retarget mid-ramp: new target latched, direction re-evaluated next cycle,
//     prescaler NOT reset (next step cadence unchanged); landing in IDLE clears it to 0.
//   target_valid on a tick edge: step uses the old target; new target visible next cycle.
//   Writing target equal to duty_out: stays/enters IDLE, no step, prescaler -> 0.
//   at_target/ramping are combinational compares of registered values (0 latency).
// CONFIGURATION
//   Macro DUTY_WDT_EN:
//   Defined: cycle counter cleared by each target_valid, else increments (saturating).
//     On the edge where it reaches WDT_CYCLES-1, wdt_tripped=1 and target forced to 0;
//     duty_out then ramps down normally. Next target_valid clears wdt_tripped, loads
//     target_in, restarts count. target_valid on the trip edge wins (no trip).
//   Undefined: no counter logic, wdt_tripped tied 0, target changes only via target_valid.
// TESTING  (WIDTH=8, RAMP_DIV=4, STEP=16, WDT_CYCLES=100)
//   Ramp up: strobe target 0x40 at edge 0 -> duty_out 0x10@4, 0x20@8, 0x30@12,
//     0x40@16; ramping=1 edges 0..15, at_target=1 from edge 16, no change after.
//   Saturation: duty 0xF8, target 0xFF -> one step to 0xFF (no wrap to 0x08);
//     duty 0x20, target 0x05 -> 0x10 then 0x05 (no underflow).
//   Retarget: ramp 0x00->0x80, write 0x00 when duty=0x30 -> 0x20, 0x10, 0x00
//     at 4-edge cadence from original phase; write on tick edge steps toward old target.
//   Reset mid-ramp: assert rst between clock edges at duty 0x30 -> duty_out=0,
//     at_target=1, ramping=0 immediately; after release, no step without a new write.
//   Watchdog (DUTY_WDT_EN): target 0x40 reached, no writes -> wdt_tripped=1 at
//     edge 99 after last write, duty ramps 0x30,0x20,0x10,0x00; write 0x20 -> flag 0.
//   Watchdog off (macro undefined): same stimulus 1000 cycles -> duty holds 0x40,
//     wdt_tripped stays 0.

Source files
------------

// File: rtl/duty_ramp.sv
// Slew-rate limiter: latches an I2C duty target and walks duty_out toward it by STEP every RAMP_DIV clocks.
// Optional watchdog (macro DUTY_WDT_EN) forces the target to 0 when no target is written for WDT_CYCLES clocks.
module duty_ramp #(
    parameter int WIDTH      = 8,
    parameter int RAMP_DIV   = 1000,
    parameter int STEP       = 1,
    parameter int WDT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] target_in,
    input  logic             target_valid,
    output logic [WIDTH-1:0] duty_out,
    output logic             at_target,
    output logic             ramping,
    output logic             wdt_tripped
);

    localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PW-1:0]  DIV_LAST = PW'(RAMP_DIV - 1);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // Elaboration-time guard against illegal parameterisations.
    if (RAMP_DIV < 1 || STEP < 1 || STEP > (2 ** WIDTH) - 1 || WDT_CYCLES < 2) begin : g_bad_params
        $error("duty_ramp: illegal parameter value");
    end

    logic [WIDTH-1:0] target;
    logic [PW-1:0]    prescaler;
    logic [WIDTH-1:0] next_duty;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   down_floor;
    logic             tick;

    assign at_target = (duty_out == target);
    assign ramping   = ~at_target;
    assign tick      = (prescaler == DIV_LAST);

`ifdef DUTY_WDT_EN
    localparam int CW = $clog2(WDT_CYCLES);
    localparam logic [CW-1:0] WDT_LAST = CW'(WDT_CYCLES - 1);

    logic [CW-1:0] wdt_count;

    // A write always wins over a trip on the same edge; the count saturates after tripping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target      <= '0;
            wdt_count   <= '0;
            wdt_tripped <= 1'b0;
        end else if (target_valid) begin
            target      <= target_in;
            wdt_count   <= '0;
            wdt_tripped <= 1'b0;
        end else if (wdt_count != WDT_LAST) begin
            wdt_count <= wdt_count + CW'(1);
            if (wdt_count == WDT_LAST - CW'(1)) begin
                wdt_tripped <= 1'b1;
                target      <= '0;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            target <= '0;
        end else if (target_valid) begin
            target <= target_in;
        end
    end

    assign wdt_tripped = 1'b0;
`endif

    // Step arithmetic is done one bit wider so neither direction can wrap past the target.
    always_comb begin
        up_sum     = {1'b0, duty_out} + STEP_EXT;
        down_floor = {1'b0, target} + STEP_EXT;
        next_duty  = duty_out;
        if (duty_out < target) begin
            next_duty = (up_sum >= {1'b0, target}) ? target : up_sum[WIDTH-1:0];
        end else if (duty_out > target) begin
            next_duty = ({1'b0, duty_out} <= down_floor) ? target : duty_out - STEP_W;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_out  <= '0;
            prescaler <= '0;
        end else if (duty_out == target) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
            duty_out  <= next_duty;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

endmodule
